imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 192 +++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Purpose : RISC-V immediate generator (format decode + imm extraction) behind a 2-entry skid buffer.
// Latency : 1 cycle from input acceptance to out_* when the buffer has room in the output register.
// Backpr. : in_ready is registered; the skid entry absorbs one beat so in_ready drops only in state TWO.
//
// Ports:
//   clk, reset (sync, active-high), flush (sync discard of both entries)
//   in_valid / in_ready / in_instr[31:0] / in_tag[TAG_W-1:0]      : upstream handshake
//   out_valid / out_ready / out_imm[XLEN-1:0] / out_fmt[2:0] /
//   out_illegal / out_tag[TAG_W-1:0]                                : downstream handshake
// Build option: define IMM_CSR_ZIMM_EN to decode CSR*I (opcode 1110011, funct3[2]=1) as
//   format Z with a zero-extended rs1-field immediate; otherwise every SYSTEM opcode is format I.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_Z   = 3'd6,
      FMT_ILL = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      logic [2:0]       fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } entry_t;

   // ------------------------------------------------------------------
   // Decode of the incoming word (purely combinational, captured on accept)
   // ------------------------------------------------------------------
   fmt_e        dec_fmt;
   logic [31:0] dec_imm32;
   entry_t      dec_ent;

   always_comb begin
      dec_fmt = FMT_ILL;
      case (in_instr[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: dec_fmt = FMT_I;
`ifdef IMM_CSR_ZIMM_EN
         7'b1110011: dec_fmt = in_instr[14] ? FMT_Z : FMT_I;
`else
         7'b1110011: dec_fmt = FMT_I;
`endif
         7'b0100011: dec_fmt = FMT_S;
         7'b1100011: dec_fmt = FMT_B;
         7'b0110111, 7'b0010111: dec_fmt = FMT_U;
         7'b1101111: dec_fmt = FMT_J;
         7'b0110011: dec_fmt = FMT_R;
         // RV64-only word ops: illegal on a 32-bit datapath
         7'b0011011: dec_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
         7'b0111011: dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
         default:    dec_fmt = FMT_ILL;
      endcase
      // Compressed / non-32-bit encodings are not handled here
      if (in_instr[1:0] != 2'b11) begin
         dec_fmt = FMT_ILL;
      end
   end

   always_comb begin
      dec_imm32 = 32'd0;
      case (dec_fmt)
         FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: dec_imm32 = {in_instr[31:12], 12'd0};
         FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
         default: dec_imm32 = 32'd0;
      endcase
   end

   always_comb begin
      dec_ent         = '0;
      // Size cast of a signed value replicates bit 31 up to XLEN
      dec_ent.imm     = XLEN'($signed(dec_imm32));
`ifdef IMM_CSR_ZIMM_EN
      if (dec_fmt == FMT_Z) begin
         dec_ent.imm = XLEN'(in_instr[19:15]);
      end
`endif
      dec_ent.fmt     = dec_fmt;
      dec_ent.illegal = (dec_fmt == FMT_ILL);
      dec_ent.tag     = in_tag;
   end

   // ------------------------------------------------------------------
   // 2-entry buffer: out_q is what the consumer sees, skid_q holds the
   // beat accepted while out_q was stalled.
   // ------------------------------------------------------------------
   state_e state_q, state_d;
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   out_valid_q, out_valid_d;
   logic   in_ready_q, in_ready_d;
   logic   in_fire, out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (flush) begin
         // Data registers keep stale contents; out_valid gates them
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  out_d   = dec_ent;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               case ({in_fire, out_fire})
                  2'b10: begin
                     skid_d  = dec_ent;
                     state_d = ST_TWO;
                  end
                  2'b01: state_d = ST_EMPTY;
                  2'b11: out_d = dec_ent;
                  default: ;
               endcase
            end
            ST_TWO: begin
               if (out_fire) begin
                  out_d   = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      // Handshake outputs are registered copies of the next-state view
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_TWO);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         out_q       <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         skid_q      <= skid_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_imm     = out_q.imm;
   assign out_fmt     = out_q.fmt;
   assign out_illegal = out_q.illegal;
   assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Purpose : directed bench for imm_gen_pipe, one XLEN=32 and one XLEN=64 instance.
// Latency : expected entries are queued on acceptance and compared when they leave the DUT.
// Backpr. : exercises stall, skid fill, drain ordering, flush and reset mid-flight.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, flush;

   // XLEN=32 instance
   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
   logic [31:0] a_in_instr, a_in_tag, a_out_imm, a_out_tag;
   logic [2:0]  a_out_fmt;

   // XLEN=64 instance
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
   logic [31:0] b_in_instr;
   logic [15:0] b_in_tag, b_out_tag;
   logic [63:0] b_out_imm;
   logic [2:0]  b_out_fmt;

   imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
      .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_tag(a_out_tag));

   imm_gen_pipe #(.XLEN(64), .TAG_W(16)) dut64 (
      .clk(clk), .reset(reset), .flush(1'b0),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
      .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_tag(b_out_tag));

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
      logic [31:0] tag;
   } exp_t;

   exp_t q32[$];
   exp_t q64[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   // Scoreboard: compare every output transfer against the oldest expected entry
   always @(negedge clk) begin : mon
      exp_t e;
      if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
         check("d32_expected_pending", 64'(q32.size() != 0), 64'd1);
         if (q32.size() != 0) begin
            e = q32.pop_front();
            check("d32_imm", 64'(a_out_imm), 64'(e.imm[31:0]));
            check("d32_fmt", 64'(a_out_fmt), 64'(e.fmt));
            check("d32_illegal", 64'(a_out_illegal), 64'(e.ill));
            check("d32_tag", 64'(a_out_tag), 64'(e.tag));
         end
      end
      if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
         check("d64_expected_pending", 64'(q64.size() != 0), 64'd1);
         if (q64.size() != 0) begin
            e = q64.pop_front();
            check("d64_imm", b_out_imm, e.imm);
            check("d64_fmt", 64'(b_out_fmt), 64'(e.fmt));
            check("d64_illegal", 64'(b_out_illegal), 64'(e.ill));
            check("d64_tag", 64'(b_out_tag), 64'(e.tag[15:0]));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 of the acceptance edge with valid dropped
   task automatic send(input bit sel, input logic [31:0] instr, input logic [31:0] tag,
                       input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
      bit   acc;
      exp_t e;
      acc = 1'b0;
      if (sel) begin
         b_in_valid = 1'b1; b_in_instr = instr; b_in_tag = tag[15:0];
      end else begin
         a_in_valid = 1'b1; a_in_instr = instr; a_in_tag = tag;
      end
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = sel ? b_in_ready : a_in_ready;
         @(posedge clk);
         #1;
      end
      check(sel ? "d64_accept" : "d32_accept", 64'(acc), 64'd1);
      e.imm = imm; e.fmt = fmt; e.ill = ill; e.tag = tag;
      if (acc) begin
         if (sel) q64.push_back(e);
         else     q32.push_back(e);
      end
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
   endtask

   initial begin
      int c0;
      exp_t e;
      reset = 1'b1; flush = 1'b0;
      a_in_valid = 1'b0; a_in_instr = '0; a_in_tag = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_instr = '0; b_in_tag = '0; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_in_ready", 64'(a_in_ready), 64'd1);
      check("rst_out_imm", 64'(a_out_imm), 64'd0);
      check("rst_out_fmt", 64'(a_out_fmt), 64'd0);
      check("rst_out_illegal", 64'(a_out_illegal), 64'd0);
      check("rst_out_tag", 64'(a_out_tag), 64'd0);
      check("rst64_out_valid", 64'(b_out_valid), 64'd0);
      check("rst64_in_ready", 64'(b_in_ready), 64'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(1);

      // Single I-type, output one cycle after acceptance
      send(0, 32'hFFF00093, 32'h100, 64'hFFFFFFFF, 3'd1, 1'b0);
      @(negedge clk);
      check("lat1_out_valid", 64'(a_out_valid), 64'd1);
      check("lat1_out_imm", 64'(a_out_imm), 64'hFFFFFFFF);
      @(posedge clk); #1;
      idle(1);

      // Back-to-back stream with out_ready high: one accept per cycle
      c0 = cycle;
      send(0, 32'hFE112E23, 32'h101, 64'hFFFFFFFC, 3'd2, 1'b0);
      send(0, 32'h00000863, 32'h102, 64'h00000010, 3'd3, 1'b0);
      send(0, 32'hFF9FF06F, 32'h103, 64'hFFFFFFF8, 3'd5, 1'b0);
      send(0, 32'h00000033, 32'h104, 64'h0, 3'd0, 1'b0);
      send(0, 32'h0000003B, 32'h105, 64'h0, 3'd7, 1'b1);
      send(0, 32'h00000090, 32'h106, 64'h0, 3'd7, 1'b1);
`ifdef IMM_CSR_ZIMM_EN
      send(0, 32'h3002D073, 32'h107, 64'h5, 3'd6, 1'b0);
`else
      send(0, 32'h3002D073, 32'h107, 64'h300, 3'd1, 1'b0);
`endif
      check("throughput_cycles", 64'(cycle - c0), 64'd7);

      // XLEN=64 instance
      send(1, 32'h800002B7, 32'h201, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      send(1, 32'h0000003B, 32'h202, 64'h0, 3'd0, 1'b0);
      send(1, 32'hFFF0009B, 32'h203, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
      send(1, 32'h00000863, 32'h204, 64'h10, 3'd3, 1'b0);
      idle(3);

      // Stall: tags 1,2 fill output+skid, tag 3 held off
      a_out_ready = 1'b0;
      e.imm = 64'hFFFFFFFF; e.fmt = 3'd1; e.ill = 1'b0;
      a_in_valid = 1'b1; a_in_instr = 32'hFFF00093; a_in_tag = 32'd1;
      @(negedge clk);
      check("bp_rdy_tag1", 64'(a_in_ready), 64'd1);
      @(posedge clk); #1;
      e.tag = 32'd1; q32.push_back(e);
      a_in_tag = 32'd2;
      @(negedge clk);
      check("bp_rdy_tag2", 64'(a_in_ready), 64'd1);
      @(posedge clk); #1;
      e.tag = 32'd2; q32.push_back(e);
      a_in_tag = 32'd3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_rdy_full", 64'(a_in_ready), 64'd0);
         check("bp_hold_valid", 64'(a_out_valid), 64'd1);
         check("bp_hold_tag", 64'(a_out_tag), 64'd1);
         @(posedge clk); #1;
      end
      a_out_ready = 1'b1;
      @(negedge clk);
      check("drain_tag1", 64'(a_out_tag), 64'd1);
      check("drain_rdy0", 64'(a_in_ready), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("drain_tag2", 64'(a_out_tag), 64'd2);
      check("drain_rdy1", 64'(a_in_ready), 64'd1);
      @(posedge clk); #1;
      e.tag = 32'd3; q32.push_back(e);
      a_in_valid = 1'b0;
      @(negedge clk);
      check("drain_tag3_valid", 64'(a_out_valid), 64'd1);
      check("drain_tag3", 64'(a_out_tag), 64'd3);
      @(posedge clk); #1;
      idle(2);

      // Flush in state TWO with input pending
      a_out_ready = 1'b0;
      send(0, 32'h00000863, 32'h301, 64'h10, 3'd3, 1'b0);
      send(0, 32'hFE112E23, 32'h302, 64'hFFFFFFFC, 3'd2, 1'b0);
      flush = 1'b1;
      a_in_valid = 1'b1; a_in_instr = 32'hFFF00093; a_in_tag = 32'h3FF;
      @(posedge clk); #1;
      flush = 1'b0; a_in_valid = 1'b0;
      q32.delete();
      @(negedge clk);
      check("flush2_out_valid", 64'(a_out_valid), 64'd0);
      check("flush2_in_ready", 64'(a_in_ready), 64'd1);
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      idle(3);

      // Flush in state ONE while an input is being accepted: input dropped
      a_out_ready = 1'b0;
      send(0, 32'h00000863, 32'h401, 64'h10, 3'd3, 1'b0);
      flush = 1'b1;
      a_in_valid = 1'b1; a_in_instr = 32'hFF9FF06F; a_in_tag = 32'h4FF;
      @(negedge clk);
      check("flush1_in_ready", 64'(a_in_ready), 64'd1);
      @(posedge clk); #1;
      flush = 1'b0; a_in_valid = 1'b0;
      q32.delete();
      @(negedge clk);
      check("flush1_out_valid", 64'(a_out_valid), 64'd0);
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      idle(3);

      // Reset mid-flight overrides flush and a pending transfer
      a_out_ready = 1'b0;
      send(0, 32'h800002B7, 32'h501, 64'h80000000, 3'd4, 1'b0);
      reset = 1'b1; flush = 1'b1;
      a_in_valid = 1'b1; a_in_instr = 32'hFFF00093; a_in_tag = 32'h5FF;
      @(posedge clk); #1;
      reset = 1'b0; flush = 1'b0; a_in_valid = 1'b0;
      q32.delete();
      @(negedge clk);
      check("rst2_out_valid", 64'(a_out_valid), 64'd0);
      check("rst2_in_ready", 64'(a_in_ready), 64'd1);
      check("rst2_out_imm", 64'(a_out_imm), 64'd0);
      check("rst2_out_tag", 64'(a_out_tag), 64'd0);
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      send(0, 32'h0000003B, 32'h601, 64'h0, 3'd7, 1'b1);
      idle(4);

      check("d32_queue_drained", 64'(q32.size()), 64'd0);
      check("d64_queue_drained", 64'(q64.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
